// File: rtl/stream_mux_n.sv
// stream_mux_n
//   N-way, WIDTH-bit valid/ready stream multiplexer with a one-entry registered
//   output stage. The source is chosen either by an external index (fixed mode)
//   or by an internal rotating-priority arbiter (round-robin mode).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   N        per-channel valid
//   in_ready   N        per-channel ready (combinational from out_ready)
//   mode_rr    1        0 = fixed select, 1 = round-robin
//   sel        SELW     source index in fixed mode
//   out_data   WIDTH    registered output word
//   out_src    SELW     channel that supplied out_data
//   out_valid  1        output holds a word
//   out_ready  1        downstream accepts
module stream_mux_n #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode_rr,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_src,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_src;
   logic             r_out_valid;
   logic [SELW-1:0]  r_ptr;

   logic             w_accept;
   logic [N-1:0]     w_grant_fix;
   logic [N-1:0]     w_req_hi;
   logic [N-1:0]     w_first_hi;
   logic [N-1:0]     w_first_lo;
   logic             w_hit_hi;
   logic             w_hit_lo;
   logic [N-1:0]     w_grant_rr;
   logic [N-1:0]     w_grant;
   logic             w_any;
   logic [SELW-1:0]  w_gidx;
   logic [WIDTH-1:0] w_sel_data;
   logic [SELW-1:0]  w_ptr_next;

   // Reset also blocks in_ready so no upstream handshake completes while the
   // output stage is being cleared.
   assign w_accept = !rst && (!r_out_valid || out_ready);

   // Fixed mode: a sel value >= N matches no channel, so nothing is granted.
   always_comb begin
      w_grant_fix = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == SELW'(i)) w_grant_fix[i] = in_valid[i];
      end
   end

   // Round-robin: first requester at or above ptr wins; if none, the lowest
   // requester below ptr wins (the wrap-around part of the search).
   always_comb begin
      w_req_hi   = '0;
      w_first_hi = '0;
      w_first_lo = '0;
      w_hit_hi   = 1'b0;
      w_hit_lo   = 1'b0;
      for (int i = 0; i < N; i++) begin
         w_req_hi[i] = in_valid[i] && (i >= int'(r_ptr));
      end
      for (int i = 0; i < N; i++) begin
         if (w_req_hi[i] && !w_hit_hi) begin
            w_first_hi[i] = 1'b1;
            w_hit_hi      = 1'b1;
         end
         if (in_valid[i] && !w_hit_lo) begin
            w_first_lo[i] = 1'b1;
            w_hit_lo      = 1'b1;
         end
      end
   end

   assign w_grant_rr = w_hit_hi ? w_first_hi : w_first_lo;
   assign w_grant    = mode_rr ? w_grant_rr : w_grant_fix;
   assign w_any      = |w_grant;
   assign in_ready   = {N{w_accept}} & w_grant;

   always_comb begin
      w_gidx     = '0;
      w_sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant[i]) begin
            w_gidx     = SELW'(i);
            w_sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_ptr_next = (int'(w_gidx) == N - 1) ? '0 : w_gidx + SELW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else if (w_accept) begin
         if (w_any) begin
            r_out_data  <= w_sel_data;
            r_out_src   <= w_gidx;
            r_out_valid <= 1'b1;
            if (mode_rr) r_ptr <= w_ptr_next;
         end else begin
            // Drain with nothing to refill: data/src keep their last values.
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Main DUT: N=4, WIDTH=32
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic         mode_rr;
   logic [1:0]   sel;
   logic [31:0]  out_data;
   logic [1:0]   out_src;
   logic         out_valid;
   logic         out_ready;

   // Second DUT: N=5, WIDTH=8 (sel can encode out-of-range indices)
   logic [39:0]  d2_in_data;
   logic [4:0]   d2_in_valid;
   logic [4:0]   d2_in_ready;
   logic         d2_mode_rr;
   logic [2:0]   d2_sel;
   logic [7:0]   d2_out_data;
   logic [2:0]   d2_out_src;
   logic         d2_out_valid;
   logic         d2_out_ready;

   stream_mux_n #(.WIDTH(32), .N(4)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode_rr(mode_rr), .sel(sel),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   stream_mux_n #(.WIDTH(8), .N(5)) dut5 (
      .clk(clk), .rst(rst),
      .in_data(d2_in_data), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .mode_rr(d2_mode_rr), .sel(d2_sel),
      .out_data(d2_out_data), .out_src(d2_out_src), .out_valid(d2_out_valid),
      .out_ready(d2_out_ready)
   );

   typedef struct {
      logic [1:0]  src;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   errors = 0;
   int   checks = 0;

   // Scoreboard consumer: an output word is consumed at the next rising edge
   // whenever out_valid & out_ready hold mid-cycle.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got src=%0d data=%h, expected no word", out_src, out_data);
         end else begin
            m_e = sb.pop_front();
            if (out_src !== m_e.src || out_data !== m_e.data) begin
               errors++;
               $display("FAIL sb_word: got src=%0d data=%h, expected src=%0d data=%h",
                        out_src, out_data, m_e.src, m_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] s, input logic [31:0] d);
      exp_t e;
      e.src  = s;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_data = '0; in_valid = '0; mode_rr = 1'b0; sel = '0; out_ready = 1'b0;
      d2_in_data = '0; d2_in_valid = '0; d2_mode_rr = 1'b0; d2_sel = '0; d2_out_ready = 1'b0;
      repeat (2) tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b d=%h s=%0d, expected 0/0/0", out_valid, out_data, out_src);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got out_valid=%b, expected 0", out_valid);
      end
      // Hold a word under stall, then reset asynchronously mid-cycle.
      in_data[31:0] = 32'h1111_1111; in_valid = 4'b0001;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1111_1111) begin
         errors++;
         $display("FAIL reset_pre_hold: got v=%b d=%h, expected 1/11111111", out_valid, out_data);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
         errors++;
         $display("FAIL reset_async: got v=%b d=%h s=%0d, expected 0/0/0", out_valid, out_data, out_src);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, expected 0000", in_ready);
      end
      in_valid = '0; out_ready = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: got out_valid=%b, expected 0", out_valid);
      end
   endtask

   task automatic test_fixed();
      mode_rr = 1'b0; sel = 2'd2; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hC0DE_0000 + i;
      in_data[64 +: 32] = 32'hDEAD_BEEF;
      in_valid = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++;
         $display("FAIL fixed_in_ready: got %b, expected 0100", in_ready);
      end
      push(2'd2, 32'hDEAD_BEEF);
      tick();
      in_valid = 4'b0000;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 2'd2) begin
         errors++;
         $display("FAIL fixed_out: got v=%b d=%h s=%0d, expected 1/deadbeef/2", out_valid, out_data, out_src);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fixed_drain: got out_valid=%b, expected 0", out_valid);
      end
      // Out-of-range select on the 5-channel instance.
      d2_mode_rr = 1'b0; d2_sel = 3'd3; d2_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) d2_in_data[i*8 +: 8] = 8'hA0 + 8'(i);
      d2_in_valid = 5'b11111;
      tick();
      checks++;
      if (d2_out_valid !== 1'b1 || d2_out_src !== 3'd3 || d2_out_data !== 8'hA3) begin
         errors++;
         $display("FAIL n5_sel3: got v=%b s=%0d d=%h, expected 1/3/a3", d2_out_valid, d2_out_src, d2_out_data);
      end
      d2_sel = 3'd7;
      #1;
      checks++;
      if (d2_in_ready !== 5'b00000) begin
         errors++;
         $display("FAIL n5_sel7_ready: got %b, expected 00000", d2_in_ready);
      end
      tick();
      checks++;
      if (d2_out_valid !== 1'b0 || d2_out_data !== 8'hA3 || d2_out_src !== 3'd3) begin
         errors++;
         $display("FAIL n5_sel7_drain: got v=%b d=%h s=%0d, expected 0/a3/3", d2_out_valid, d2_out_data, d2_out_src);
      end
      d2_in_valid = '0;
   endtask

   task automatic rr_run(input logic [3:0] valid, input int ncyc, input logic [1:0] seq [4]);
      in_valid = valid;
      for (int c = 0; c < ncyc; c++) begin
         logic [1:0] ex;
         ex = seq[c % 4];
         #1;
         checks++;
         if (in_ready !== (4'b0001 << ex)) begin
            errors++;
            $display("FAIL rr_in_ready[%0d]: got %b, expected channel %0d", c, in_ready, ex);
         end
         push(ex, 32'(ex));
         tick();
         checks++;
         if (out_src !== ex) begin
            errors++;
            $display("FAIL rr_out_src[%0d]: got %0d, expected %0d", c, out_src, ex);
         end
      end
   endtask

   task automatic test_rr_fairness();
      logic [1:0] s_all [4];
      logic [1:0] s_odd [4];
      s_all = '{2'd0, 2'd1, 2'd2, 2'd3};
      s_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
      mode_rr = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'(i);
      rr_run(4'b1111, 8, s_all);
      rr_run(4'b1010, 4, s_odd);
      in_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      mode_rr = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hB0 + i;
      in_valid = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL bp_first_grant: got %b, expected 0001", in_ready);
      end
      push(2'd0, 32'hB0);
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hB0) begin
            errors++;
            $display("FAIL bp_stall[%0d]: got rdy=%b v=%b s=%0d d=%h, expected 0000/1/0/b0",
                     c, in_ready, out_valid, out_src, out_data);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release_grant: got %b, expected 0010", in_ready);
      end
      push(2'd1, 32'hB1);
      tick();
      in_valid = '0;
      tick();
   endtask

   task automatic test_mode_switch();
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h50 + i;
      out_ready = 1'b1;
      // ptr is 2 here; one RR transfer on channel 2 moves it to 3.
      mode_rr = 1'b1; in_valid = 4'b0100;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++;
         $display("FAIL ms_rr_setup: got %b, expected 0100", in_ready);
      end
      push(2'd2, 32'h52);
      tick();
      mode_rr = 1'b0; sel = 2'd0; in_valid = 4'b1111;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL ms_fixed[%0d]: got %b, expected 0001", c, in_ready);
         end
         push(2'd0, 32'h50);
         tick();
      end
      mode_rr = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++;
         $display("FAIL ms_rr_resume: got %b, expected 1000", in_ready);
      end
      push(2'd3, 32'h53);
      tick();
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL ms_rr_wrap: got %b, expected 0001", in_ready);
      end
      push(2'd0, 32'h50);
      tick();
      in_valid = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      mode_rr = 1'b0; sel = 2'd1; out_ready = 1'b1; in_valid = 4'b0010;
      for (int w = 0; w < 100; w++) begin
         d = $urandom;
         in_data[32 +: 32] = d;
         #1;
         checks++;
         if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_ready[%0d]: got %b, expected 0010", w, in_ready);
         end
         if (w > 0) begin
            checks++;
            if (out_valid !== 1'b1) begin
               errors++;
               $display("FAIL b2b_valid[%0d]: got out_valid=%b, expected 1", w, out_valid);
            end
         end
         push(2'd1, d);
         tick();
      end
      in_valid = '0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got out_valid=%b, expected 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_rr_fairness();
      test_backpressure();
      test_mode_switch();
      test_back_to_back();
      for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d words still expected, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-way, WIDTH-bit stream multiplexer with valid/ready handshakes and a one-entry registered output stage.
- Successor to the combinational 2x1 datapath mux, for datapath/bus paths that need flow control and fair sharing, e.g. arbitrating fetch/load requests onto one memory port.
- Two runtime modes:
  - Fixed select: external index chooses the source.
  - Round-robin: internal rotating-priority arbiter chooses the source.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (N >= 1).
- SELW, $clog2(N) (min 1), width of sel and out_src; derived localparam, not overridable.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- mode_rr  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  source index in fixed mode; ignored in RR mode.
- out_data  output  WIDTH  registered output data.
- out_src  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (async assert, sync-released by the integrator): out_valid=0, out_data=0, out_src=0, RR pointer ptr=0. Asserting rst mid-transfer discards the held word; no handshake completes in a cycle where rst is high.
- Acceptance: accept = !out_valid || out_ready. Throughput is 1 word/cycle; latency is 1 cycle from input handshake to out_valid.
- Grant (combinational, at most one bit set):
  - Fixed mode: grant[sel] = in_valid[sel] when sel < N. If sel >= N, no grant; out_valid falls once the held word drains.
  - RR mode: search from ptr upward, wrapping at N-1 -> 0. Grant the first i with in_valid[i].
- in_ready[i] = accept & grant[i]. in_ready does not depend on in_valid of other channels except through the grant.
- Handshake on channel g (in_valid[g] & in_ready[g]) at edge: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- If accept=1 and no grant: out_valid <= 0, and out_data/out_src hold their last values.
- Stall (out_valid & !out_ready): out_data, out_src, out_valid are stable and all in_ready=0. Upstream must hold its in_valid/in_data. The block tolerates a drop and does not fault on one.
- Pointer update:
  - RR mode with a completed handshake on g: ptr <= (g == N-1) ? 0 : g+1.
  - Otherwise ptr holds, including in fixed mode and during stalls.
- Mode switch: mode_rr is sampled combinationally and takes effect for the grant in the same cycle. ptr is preserved across switches.
- Simultaneous events:
  - Output drain and new capture in the same cycle is legal; out_valid stays 1.
  - With all N channels valid in RR mode, the service order is strictly ptr, ptr+1, …; no channel waits more than N-1 grants.
- N=1: sel/out_src are 1 bit, always 0. Both modes reduce to a registered pipe stage.
- No combinational path from in_* to out_*. The only comb path is out_ready -> in_ready.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid, out_data, out_src, ptr all 0 immediately, without waiting for a clock edge. After release with no inputs valid, out_valid stays 0.
- Fixed mode, N=4, WIDTH=32: sel=2, in_valid=4'b1111, in_data[2]=32'hDEADBEEF, out_ready=1 -> next cycle out_data=DEADBEEF, out_src=2, in_ready=4'b0100. sel=5 (SELW=2 cannot encode it; use N=5 with sel=7) -> in_ready=0 and out_valid drops.
- RR fairness: all in_valid=1, out_ready=1, channel i data = i -> out_src sequence 0,1,2,3,0,… each cycle. Then in_valid=4'b1010 from ptr=0 -> sequence 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_src frozen, in_ready=0, ptr unchanged. Release -> the next grant follows the pre-stall ptr with no word lost or duplicated.
- Mode switch: RR with ptr=3, switch to fixed sel=0 for 2 transfers, then back to RR with all valid -> first RR grant is channel 3.
- Back-to-back drain and fill: out_valid=1, out_ready=1, in_valid[1]=1 -> out_valid stays 1 with new data, 1 word/cycle sustained over 100 random words. The scoreboard matches order and source.
